apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
CPU-side APB4 initiator that converts a simple valid/ready request/response interface into APB SETUP/ACCESS transactions. It drives the master port of the peripheral interconnect.
- Handles one outstanding transfer at a time.
- Captures read data and slave errors from the completer.
- Aborts transfers whose completer never asserts PREADY, using a programmable timeout.

Parameters:
TIMEOUT_CYCLES, 256, max ACCESS cycles with pready=0 before abort; 0 disables timeout
ADDR_W, 32, address width

Ports:
pclk  in  1  clock
preset  in  1  reset; asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  bridge can accept request
req_addr  in  ADDR_W  byte address
req_write  in  1  1=write, 0=read
req_wdata  in  32  write data
req_strb  in  4  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes/errors)
rsp_err  out  1  slave error or timeout
rsp_timeout  out  1  transfer aborted by timeout
m_paddr  out  ADDR_W  APB address
m_psel  out  1  APB select
m_penable  out  1  APB enable
m_pwrite  out  1  APB direction
m_pwdata  out  32  APB write data
m_pstrb  out  4  APB strobes (forced 4'b0000 on reads)
m_pready  in  1  completer ready
m_prdata  in  32  completer read data
m_pslverr  in  1  completer error

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; every output 0; internal counter=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1, psel=0, penable=0.
  - On req_valid: latch addr/write/wdata/strb into APB output regs and go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, then go to ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=1: capture rdata (reads only, else 0) and err=pslverr, timeout=0; go to RESP.
  - pready=0: increment wait counter.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES (i.e. TIMEOUT_CYCLES consecutive ACCESS cycles with pready=0): drop psel/penable; go to RESP with err=1, timeout=1, rdata=0.
- RESP: psel=0, penable=0, rsp_valid=1; rsp fields stable until rsp_ready. On rsp_ready go to IDLE and clear the counter.
- req_ready=0 in all states except IDLE; requests are never accepted while a transfer or response is pending.
- APB stability: paddr/pwrite/pwdata/pstrb are constant from SETUP through the end of ACCESS. In IDLE/RESP they hold their last value (no toggling).
- Latency: request accepted at cycle N; SETUP N+1; ACCESS N+2; with zero wait states rsp_valid at N+3. Each wait state adds 1 cycle.
- Back-to-back minimum period: 4 cycles per transfer with rsp_ready held high.
- A reset asserted mid-transfer returns to IDLE immediately and clears psel/penable asynchronously. No response is generated for the aborted transfer.
- pslverr is sampled only in the pready=1 cycle. pready, prdata and pslverr are ignored outside ACCESS.
- The counter width is sized to hold TIMEOUT_CYCLES. It saturates and never wraps.

Test Plan:
- Read req_addr=0x0000_0100, slave pready=1 immediately, prdata=0xDEAD_BEEF -> psel rises at N+1, penable at N+2, rsp_valid at N+3 with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write addr=0x0002_8004, wdata=0x1234_5678, strb=4'b0011, slave inserts 3 wait states -> pwdata/pstrb stable across all 4 ACCESS cycles, rsp_valid at N+6, rsp_rdata=0.
- Read to unmapped 0x0003_0000 (interconnect returns pready=1, pslverr=1) -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYCLES=8, slave pready stuck 0 -> after 8 ACCESS cycles psel/penable drop; rsp_err=1, rsp_timeout=1; a subsequent normal read completes correctly.
- rsp_ready held 0 for 5 cycles with req_valid=1 -> rsp fields stable, req_ready=0 throughout; next request accepted only after rsp_ready handshake.
- Assert preset during ACCESS wait state -> psel/penable/rsp_valid go 0 asynchronously; state IDLE; req_ready=1 after reset release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 initiator: turns a valid/ready request/response pair into APB SETUP/ACCESS
// transfers, one outstanding at a time, with an optional stuck-completer timeout.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid=1, holding the response until rsp_ready
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_paddr,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [31:0]       m_pwdata,
  output logic [3:0]        m_pstrb,
  input  logic              m_pready,
  input  logic [31:0]       m_prdata,
  input  logic              m_pslverr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             accept;
  logic             access_done;
  logic             timeout_hit;

  assign accept      = (state_q == ST_IDLE) && req_ready && req_valid;
  assign access_done = (state_q == ST_ACCESS) && m_pready;
  // Down-counter loaded in SETUP; reaching 1 on a wait cycle means this is the
  // TIMEOUT_CYCLES-th consecutive ACCESS cycle without pready.
  assign timeout_hit = TIMEOUT_EN && (state_q == ST_ACCESS) && !m_pready &&
                       (wait_cnt_q == CNT_ONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (access_done || timeout_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
      m_psel    <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      m_penable <= (state_d == ST_ACCESS);
    end
  end

  // APB payload only changes on acceptance, so it holds through SETUP/ACCESS/RESP/IDLE.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_paddr  <= '0;
      m_pwrite <= 1'b0;
      m_pwdata <= '0;
      m_pstrb  <= '0;
    end else if (accept) begin
      m_paddr  <= req_addr;
      m_pwrite <= req_write;
      m_pwdata <= req_wdata;
      m_pstrb  <= req_write ? req_strb : 4'b0000;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      wait_cnt_q <= CNT_LOAD;
    end else if ((state_q == ST_ACCESS) && !m_pready && (wait_cnt_q != CNT_ZERO)) begin
      wait_cnt_q <= wait_cnt_q - CNT_ONE;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      wait_cnt_q <= '0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (access_done) begin
      rsp_rdata   <= (!m_pwrite && !m_pslverr) ? m_prdata : 32'h0;
      rsp_err     <= m_pslverr;
      rsp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, hand-written
// reset sequences and randomized transfers against a transaction-level model.
module tb_apb_master_bridge;

  localparam int T = 8;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] m_paddr;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic        m_pready = 1'b0;
  logic [31:0] m_prdata = '0;
  logic        m_pslverr = 1'b0;

  apb_master_bridge #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  always @(posedge pclk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Completer: pready after s_ws wait states, junk on every ignored cycle.
  int          s_ws = 0;
  logic        s_err = 1'b0;
  logic [31:0] s_rdata = '0;
  int          acc_n = 0;
  always @(posedge pclk) begin
    #1;
    if (m_psel && m_penable) begin
      if (acc_n == s_ws) begin
        m_pready  = 1'b1;
        m_prdata  = s_rdata;
        m_pslverr = s_err;
      end else begin
        m_pready  = 1'b0;
        m_prdata  = $urandom;
        m_pslverr = 1'($urandom_range(0, 1));
      end
      acc_n++;
    end else begin
      acc_n     = 0;
      m_pready  = 1'($urandom_range(0, 1));
      m_prdata  = $urandom;
      m_pslverr = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;
    logic        err;
    logic [31:0] srdata;
    int          rdelay;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  // Transaction-level expectation: cycles from acceptance to rsp_valid and response fields.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int access_cycles;
    r.exp_to = (v.ws >= T);
    access_cycles = r.exp_to ? T : v.ws + 1;
    r.exp_lat = 1 + access_cycles + 1;
    r.exp_err = r.exp_to || v.err;
    r.exp_rdata = (v.write || r.exp_err) ? 32'h0 : v.srdata;
    return r;
  endfunction

  task automatic run_xfer(input vec_t v, input string name, output int acc_cycle);
    logic       acc = 1'b0;
    logic       stable = 1'b1, rr_low = 1'b1, rsp_hold = 1'b1;
    logic       setup_ok = 1'b0, enable_ok = 1'b0;
    logic [3:0] exp_strb;
    int         lat = 0;
    acc_cycle = 0;
    s_ws = v.ws; s_err = v.err; s_rdata = v.srdata;
    req_valid = 1'b1; req_addr = v.addr; req_write = v.write;
    req_wdata = v.wdata; req_strb = v.strb;
    for (int i = 0; i < 20 && !acc; i++) begin
      logic rr;
      rr = req_ready;
      @(posedge pclk); #1;
      if (rr) acc = 1'b1;
    end
    chk({name, " accept"}, 64'(acc), 64'd1);
    if (!acc) begin
      req_valid = 1'b0;
      return;
    end
    acc_cycle = cyc_cnt;
    exp_strb = v.write ? v.strb : 4'b0000;
    // Keep req_valid high with new junk fields: nothing may be taken while busy.
    req_addr = $urandom; req_wdata = $urandom; req_strb = 4'($urandom);
    req_write = 1'($urandom_range(0, 1));
    for (int c = 1; c <= 40; c++) begin
      if (m_paddr !== v.addr || m_pwrite !== v.write || m_pwdata !== v.wdata ||
          m_pstrb !== exp_strb) stable = 1'b0;
      if (req_ready) rr_low = 1'b0;
      if (c == 1) setup_ok = m_psel && !m_penable && !rsp_valid;
      if (c == 2) enable_ok = m_psel && m_penable && !rsp_valid;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge pclk); #1;
    end
    chk({name, " latency"}, 64'(lat), 64'(v.exp_lat));
    chk({name, " setup_phase"}, 64'(setup_ok), 64'd1);
    chk({name, " access_phase"}, 64'(enable_ok), 64'd1);
    if (lat == 0) begin
      req_valid = 1'b0;
      return;
    end
    chk({name, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    chk({name, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    chk({name, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
    chk({name, " bus_idle_in_resp"}, 64'({m_psel, m_penable}), 64'd0);
    for (int d = 0; d <= v.rdelay; d++) begin
      if (d == v.rdelay) rsp_ready = 1'b1;
      if (!rsp_valid || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
          rsp_timeout !== v.exp_to || m_psel || m_penable) rsp_hold = 1'b0;
      if (req_ready) rr_low = 1'b0;
      if (m_paddr !== v.addr || m_pwrite !== v.write || m_pwdata !== v.wdata ||
          m_pstrb !== exp_strb) stable = 1'b0;
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({name, " apb_payload_stable"}, 64'(stable), 64'd1);
    chk({name, " req_ready_low_busy"}, 64'(rr_low), 64'd1);
    chk({name, " rsp_held"}, 64'(rsp_hold), 64'd1);
    chk({name, " back_to_idle"}, 64'({rsp_valid, req_ready, m_psel}), 64'b010);
  endtask

  vec_t  vecs[11];
  string names[11];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_t;
    int prev_acc;
    vec_t v;
    //           addr         wr  wdata         strb   ws    err  srdata        dly  exp_rdata     err to lat
    vecs[0]  = '{32'h0000_0100, 0, 32'h0,        4'hF,  0,    0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 3};
    vecs[1]  = '{32'h0002_8004, 1, 32'h1234_5678, 4'h3,  3,    0, 32'h5555_AAAA, 0, 32'h0,        0, 0, 6};
    vecs[2]  = '{32'h0003_0000, 0, 32'h0,        4'h0,  0,    1, 32'hCAFE_F00D, 0, 32'h0,        1, 0, 3};
    vecs[3]  = '{32'h0000_0200, 0, 32'h0,        4'h0,  1000, 0, 32'h1111_1111, 1, 32'h0,        1, 1, 10};
    vecs[4]  = '{32'h0000_0104, 0, 32'h0,        4'h0,  1,    0, 32'hA5A5_0001, 0, 32'hA5A5_0001, 0, 0, 4};
    vecs[5]  = '{32'h0000_0108, 0, 32'h0,        4'h0,  2,    0, 32'h0BAD_C0DE, 5, 32'h0BAD_C0DE, 0, 0, 5};
    vecs[6]  = '{32'h0000_010C, 0, 32'h0,        4'h0,  7,    0, 32'h7777_0007, 0, 32'h7777_0007, 0, 0, 10};
    vecs[7]  = '{32'h0000_0110, 1, 32'h8888_0008, 4'h5,  8,    0, 32'h0,        0, 32'h0,        1, 1, 10};
    vecs[8]  = '{32'h0000_0114, 1, 32'hFFFF_0000, 4'hF,  2,    1, 32'h0,        0, 32'h0,        1, 0, 5};
    vecs[9]  = '{32'h0000_0118, 0, 32'h0,        4'h0,  0,    0, 32'h1357_9BDF, 0, 32'h1357_9BDF, 0, 0, 3};
    vecs[10] = '{32'h0000_011C, 1, 32'h2468_ACE0, 4'hC,  0,    0, 32'h0,        0, 32'h0,        0, 0, 3};
    names = '{"rd_basic", "wr_3ws", "rd_slverr", "rd_timeout", "rd_after_to",
              "rd_rsp_stall", "rd_7ws_edge", "wr_8ws_to", "wr_slverr",
              "rd_b2b_a", "wr_b2b_b"};

    #2 preset = 1'b1;
    @(posedge pclk); #1;
    chk("reset_outputs",
        64'({req_ready, rsp_valid, rsp_err, rsp_timeout, m_psel, m_penable, m_pwrite,
             m_pstrb, (|rsp_rdata), (|m_paddr), (|m_pwdata)}), 64'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    chk("req_ready_after_reset", 64'(req_ready), 64'd1);

    prev_acc = 0;
    for (int i = 0; i < 11; i++) begin
      run_xfer(vecs[i], names[i], acc_t);
      if (i == 10) chk("b2b_period", 64'(acc_t - prev_acc), 64'd4);
      prev_acc = acc_t;
    end

    // Reset during an ACCESS wait state.
    s_ws = 1000;
    req_valid = 1'b1; req_addr = 32'h0000_0400; req_write = 1'b0;
    @(posedge pclk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    chk("pre_reset_in_access", 64'({m_psel, m_penable}), 64'b11);
    #3 preset = 1'b1;
    #1;
    chk("async_reset_clears", 64'({m_psel, m_penable, rsp_valid, req_ready}), 64'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(posedge pclk); #1;
    chk("idle_after_mid_reset", 64'({req_ready, m_psel, m_penable, rsp_valid}), 64'b1000);
    @(posedge pclk); #1;
    chk("no_rsp_for_aborted", 64'(rsp_valid), 64'd0);
    v = model('{32'h0000_0500, 0, 32'h0, 4'h0, 0, 0, 32'h600D_F00D, 0, 0, 0, 0, 0});
    run_xfer(v, "rd_after_reset", acc_t);

    for (int i = 0; i < 30; i++) begin
      v.addr   = $urandom & 32'hFFFF_FFFC;
      v.write  = 1'($urandom_range(0, 1));
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.ws     = $urandom_range(0, 10);
      v.err    = 1'($urandom_range(0, 1));
      v.srdata = $urandom;
      v.rdelay = $urandom_range(0, 3);
      v = model(v);
      run_xfer(v, $sformatf("rand%0d", i), acc_t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
